// File: rtl/vga_line_fetch.sv
// vga_line_fetch: fetches one image row per request into a ping-pong line buffer and streams the front bank to the display window
module vga_line_fetch #(
  parameter int ADDR_W = 16,
  parameter int PIX_W  = 12,
  parameter int MAX_W  = 240,
  parameter int H_DISP = 800
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        state,
  input  logic [7:0]        W,
  input  logic [7:0]        H,
  input  logic [9:0]        STARTROW,
  input  logic [9:0]        STARTCOL,
  input  logic              spram_rd_sig,
  input  logic [11:0]       xpos,
  input  logic [11:0]       ypos,
  output logic              spram_rden,
  output logic [ADDR_W-1:0] spram_addr,
  input  logic [PIX_W-1:0]  spram_rdata,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  output logic              busy,
  output logic              overrun
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fsm_t;
  localparam logic [11:0] XMAX = 12'(H_DISP);
  fsm_t fsm;
  logic [7:0] col, col_d, row, row_nx;
  logic [15:0] base, base_nx, addr_nx;
  logic rden_d, sel, front_valid, run, wrap, hit;
  logic [11:0] dx, dy;
  logic [PIX_W-1:0] bank0 [MAX_W];
  logic [PIX_W-1:0] bank1 [MAX_W];
  assign run = state == 8'h03;
  assign busy = fsm != IDLE;
  assign dx = xpos - {2'b0, STARTCOL};
  assign dy = ypos - {2'b0, STARTROW};
  // window is additionally clipped to the active region
  assign hit = dx < {4'b0, W} && dy < {4'b0, H} && xpos < XMAX && front_valid && run;
  assign wrap = row + 8'd1 >= H;
  assign row_nx = wrap ? 8'd0 : row + 8'd1;
  assign base_nx = wrap ? 16'd0 : base + {8'b0, W};
  assign addr_nx = base + {8'b0, col} + 16'd1;
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm <= IDLE;
      col <= '0;
      col_d <= '0;
      rden_d <= 1'b0;
      row <= '0;
      base <= '0;
      sel <= 1'b0;
      front_valid <= 1'b0;
      spram_rden <= 1'b0;
      spram_addr <= '0;
      overrun <= 1'b0;
      pix_data <= '0;
      pix_valid <= 1'b0;
    end else begin
      rden_d <= spram_rden;
      col_d <= col;
      pix_valid <= hit;
      pix_data <= hit ? (sel ? bank1[dx[7:0]] : bank0[dx[7:0]]) : '0;
      if (busy && (spram_rd_sig || xpos == 12'hFFF)) overrun <= 1'b1;
      if (!run) begin
        fsm <= IDLE;
        spram_rden <= 1'b0;
        rden_d <= 1'b0;
        row <= '0;
        base <= '0;
        col <= '0;
        front_valid <= 1'b0;
      end else begin
        case (fsm)
          IDLE: if (spram_rd_sig) begin
            if (W == 8'd0) begin
              row <= row_nx;
              base <= base_nx;
            end else begin
              fsm <= FETCH;
              spram_rden <= 1'b1;
              spram_addr <= ADDR_W'(base);
              col <= '0;
            end
          end
          FETCH: if (col == W - 8'd1) begin
            fsm <= DRAIN;
            spram_rden <= 1'b0;
          end else begin
            col <= col + 8'd1;
            spram_addr <= ADDR_W'(addr_nx);
          end
          DRAIN: begin
            fsm <= IDLE;
            sel <= ~sel;
            front_valid <= 1'b1;
            row <= row_nx;
            base <= base_nx;
          end
          default: fsm <= IDLE;
        endcase
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && rden_d) begin
      if (sel) bank0[col_d] <= spram_rdata;
      else bank1[col_d] <= spram_rdata;
    end
  end
endmodule

// File: tb/tb_vga_line_fetch.sv
// tb_vga_line_fetch: directed checks of fetch sequencing, display window, overrun and abort
module tb_vga_line_fetch;
  logic clk = 0, rst = 1, spram_rd_sig = 1, spram_rden, pix_valid, busy, overrun;
  logic [7:0] state = 8'h03, W = 8'd4, H = 8'd2;
  logic [9:0] STARTROW = 10'd5, STARTCOL = 10'd10;
  logic [11:0] xpos = 12'd100, ypos = 12'd5;
  logic [15:0] spram_addr;
  logic [11:0] spram_rdata = '0, pix_data;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  always @(posedge clk) spram_rdata <= spram_addr[11:0];
  vga_line_fetch dut (
    .clk(clk), .rst(rst), .state(state), .W(W), .H(H), .STARTROW(STARTROW), .STARTCOL(STARTCOL),
    .spram_rd_sig(spram_rd_sig), .xpos(xpos), .ypos(ypos), .spram_rden(spram_rden),
    .spram_addr(spram_addr), .spram_rdata(spram_rdata), .pix_data(pix_data),
    .pix_valid(pix_valid), .busy(busy), .overrun(overrun)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic fetch(input int b, input int n);
    spram_rd_sig = 1;
    step();
    spram_rd_sig = 0;
    for (int i = 0; i < n; i++) begin
      chk("fetch_rden", 32'(spram_rden), 1);
      chk("fetch_addr", 32'(spram_addr), 32'(b + i));
      chk("fetch_busy", 32'(busy), 1);
      step();
    end
    chk("drain_rden", 32'(spram_rden), 0);
    chk("drain_busy", 32'(busy), 1);
    step();
    chk("idle_busy", 32'(busy), 0);
  endtask
  task automatic sweep(input int off);
    for (int x = 8; x < 16; x++) begin
      xpos = 12'(x);
      step();
      chk("sweep_valid", 32'(pix_valid), (x >= 10 && x <= 13) ? 1 : 0);
      chk("sweep_data", 32'(pix_data), (x >= 10 && x <= 13) ? 32'(off + x - 10) : 0);
    end
    xpos = 12'd100;
  endtask
  initial begin
    repeat (3) step();
    chk("rst_rden", 32'(spram_rden), 0);
    chk("rst_addr", 32'(spram_addr), 0);
    chk("rst_pvalid", 32'(pix_valid), 0);
    chk("rst_pdata", 32'(pix_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overrun", 32'(overrun), 0);
    rst = 0;
    spram_rd_sig = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_rst_rden", 32'(spram_rden), 0);
    end
    fetch(0, 4);
    sweep(0);
    fetch(4, 4);
    sweep(4);
    fetch(0, 4);
    chk("no_overrun", 32'(overrun), 0);
    spram_rd_sig = 1;
    step();
    spram_rd_sig = 0;
    chk("b2b_addr0", 32'(spram_addr), 4);
    step();
    chk("b2b_addr1", 32'(spram_addr), 5);
    spram_rd_sig = 1;
    step();
    spram_rd_sig = 0;
    chk("b2b_addr2", 32'(spram_addr), 6);
    chk("b2b_overrun", 32'(overrun), 1);
    step();
    chk("b2b_addr3", 32'(spram_addr), 7);
    step();
    chk("b2b_drain", 32'(spram_rden), 0);
    step();
    chk("b2b_idle", 32'(busy), 0);
    rst = 1;
    step();
    rst = 0;
    chk("rst_clears_overrun", 32'(overrun), 0);
    W = 8'd240;
    xpos = 12'd800;
    spram_rd_sig = 1;
    step();
    spram_rd_sig = 0;
    for (int c = 1; c <= 241; c++) begin
      if (c == 1) chk("ovr_busy_first", 32'(busy), 1);
      if (c == 239) chk("ovr_before", 32'(overrun), 0);
      if (c == 240) chk("ovr_at_fff", 32'(overrun), 1);
      if (c == 241) begin
        chk("ovr_drain_busy", 32'(busy), 1);
        chk("ovr_drain_rden", 32'(spram_rden), 0);
      end
      xpos = (c == 239) ? 12'hFFF : 12'(801 + c);
      step();
    end
    chk("ovr_done", 32'(busy), 0);
    xpos = 12'd249;
    step();
    chk("ovr_swap_valid", 32'(pix_valid), 1);
    chk("ovr_swap_data", 32'(pix_data), 239);
    chk("ovr_sticky", 32'(overrun), 1);
    W = 8'd100;
    xpos = 12'd10;
    spram_rd_sig = 1;
    step();
    spram_rd_sig = 0;
    for (int c = 1; c <= 20; c++) begin
      chk("abort_rden", 32'(spram_rden), 1);
      chk("abort_addr", 32'(spram_addr), 32'(240 + c - 1));
      if (c < 20) step();
    end
    chk("abort_pvalid_pre", 32'(pix_valid), 1);
    state = 8'h01;
    step();
    chk("abort_rden_off", 32'(spram_rden), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_pvalid", 32'(pix_valid), 0);
    chk("abort_pdata", 32'(pix_data), 0);
    state = 8'h03;
    step();
    chk("abort_front_invalid", 32'(pix_valid), 0);
    chk("abort_overrun_held", 32'(overrun), 1);
    W = 8'd4;
    xpos = 12'd100;
    fetch(0, 4);
    W = 8'd0;
    spram_rd_sig = 1;
    step();
    spram_rd_sig = 0;
    chk("w0_rden", 32'(spram_rden), 0);
    chk("w0_busy", 32'(busy), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_line_fetch.md
# vga_line_fetch

Reader/responder for the VGA timing generator's per-line SPRAM read request. On each `spram_rd_sig` pulse it reads one image row of `W` pixels from SPRAM into a ping-pong line buffer. During the next line's display region it streams that row out as `pix_data`, aligned to `xpos`/`ypos` inside the window [`STARTCOL`, `STARTCOL+W`) × [`STARTROW`, `STARTROW+H`). It sits between the timing generator, the image SPRAM and the RGB output stage.

## Interface
Parameters:
- `ADDR_W`, 16: SPRAM word-address width.
- `PIX_W`, 12: pixel width (RGB444).
- `MAX_W`, 240: line-buffer depth per bank. `W` must not exceed it.
- `H_DISP`, 800: active pixels per line.

Ports:
- `clk` in 1: pixel clock.
- `rst` in 1: synchronous, active-high reset.
- `state` in 8: system state. The block operates only at 8'h03.
- `W` in 8: image width in pixels.
- `H` in 8: image height in pixels.
- `STARTROW` in 10: first display row of the image.
- `STARTCOL` in 10: first display column of the image.
- `spram_rd_sig` in 1: one-cycle row-fetch request from the timing generator.
- `xpos` in 12: display-relative X; wraps, 12'hFFF is the cycle before column 0.
- `ypos` in 12: display-relative Y.
- `spram_rden` out 1: SPRAM read enable.
- `spram_addr` out ADDR_W: SPRAM read address.
- `spram_rdata` in PIX_W: SPRAM data, valid exactly 1 cycle after `spram_rden`.
- `pix_data` out PIX_W: output pixel, 0 outside the image window.
- `pix_valid` out 1: `pix_data` is an image pixel.
- `busy` out 1: fetch in progress.
- `overrun` out 1: sticky fetch-timing error flag.

## Operation
- State machine: IDLE, FETCH, DRAIN.
- IDLE → FETCH on `spram_rd_sig`=1 while `state`==8'h03. At entry, `col` is cleared to 0.
- FETCH:
  - Each cycle: `spram_rden`=1, `spram_addr`=`base`+`col`, `col`++.
  - Last issue is at `col`==`W`-1, then go to DRAIN.
- DRAIN: one cycle to capture the final datum, then go to IDLE.
- Data capture: data returning 1 cycle after each issue is written to the back bank at index `col_d` (the column delayed by 1).
- On completion (DRAIN exit):
  - swap banks;
  - set `front_valid`;
  - `base` += `W` and `row`++;
  - if `row` reaches `H`, then `row`=0 and `base`=0 (next frame restarts at address 0).
- Address arithmetic: `base` is 16-bit accumulative, with no multiplier. The sum `base`+`col` is truncated to ADDR_W.
- `W`=0: the request is ignored, no reads are issued and no swap happens. `row` and `base` still advance.
- Display path:
  - `hit` is (`xpos`−`STARTCOL`) < `W` and (`ypos`−`STARTROW`) < `H`, both computed as unsigned 12-bit.
  - If `hit` and `front_valid`: `pix_data`=front[`xpos`−`STARTCOL`] and `pix_valid`=1.
  - Otherwise `pix_data`=0 and `pix_valid`=0.
- Overrun: `overrun` is set (sticky until `rst`) in either case:
  - `spram_rd_sig` arrives while `busy`; that request is dropped.
  - `xpos`==12'hFFF occurs while `busy`.
  - A fetch that has been flagged still completes and swaps.
- `state`≠8'h03, including mid-fetch:
  - next cycle: FSM to IDLE, `spram_rden`=0;
  - `row`, `base`, `col` cleared;
  - `front_valid`=0;
  - `pix_valid`=0, `pix_data`=0.
  - `overrun` is held.
- Buffers are not cleared by reset. `front_valid` gates their use.

## Timing
- Reset values:
  - `spram_rden`=0, `spram_addr`=0;
  - `pix_data`=0, `pix_valid`=0;
  - `busy`=0, `overrun`=0;
  - FSM IDLE, `row`=0, `base`=0, `front_valid`=0, bank select 0.
- Fetch latency:
  - the first `spram_rden` is in the cycle after the `spram_rd_sig` sample;
  - W consecutive enables follow;
  - `busy`=1 from the first enable through DRAIN (W+1 cycles);
  - the swap is visible on the cycle after DRAIN.
- Blanking budget: the request is sampled at `xpos`==`H_DISP`+1 (registered pulse), and 239 cycles remain before `xpos`==0. Therefore W≤237 completes overrun-free; W≥238 flags `overrun`.
- Display latency: `pix_data`/`pix_valid` are registered 1 cycle after the `xpos`/`ypos` they correspond to.
- Simultaneous `spram_rd_sig` and DRAIN exit: the request is dropped, `overrun` is set, and the swap proceeds.
- `rst` has priority over everything, including `state`.

## Test plan
- Reset: assert `rst` 3 cycles with `state`=3 and `spram_rd_sig`=1 → all outputs 0; no `spram_rden` for 5 cycles after release with `spram_rd_sig` low.
- Single row: W=4, H=2, model rdata=addr, pulse `spram_rd_sig` → `spram_rden` high 4 cycles, `spram_addr` 0,1,2,3, `busy` 5 cycles. Then sweep `xpos` with STARTCOL=10, `ypos`=STARTROW → `pix_valid` for `xpos` 10..13 one cycle later, `pix_data` 0,1,2,3, and 0 at `xpos` 9 and 14.
- Row stepping and wrap: W=4, H=2, three requests → addresses 0–3, then 4–7, then 0–3 again; `row` wraps after the second.
- Overrun: W=240, request at `xpos`=800, `xpos` advancing per clock → `overrun`=1 at `xpos`==12'hFFF. The fetch completes and the swap occurs; `overrun` stays 1 until `rst`.
- Abort: W=100, drop `state` to 8'h01 after 20 enables → `spram_rden`=0 the next cycle, `pix_valid`=0. After returning to 3, the next request starts at address 0.
- Back-to-back: a second `spram_rd_sig` during FETCH → ignored (no restart of `spram_addr`), `overrun`=1.
